// File: rtl/piano_pkg.sv
// Shared note codes, sequencer state encoding and note width for the piano player.
package piano_pkg;

  localparam int unsigned NOTE_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_SOL  = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_TI   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_HDO  = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_HRE  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_HMI  = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_HFA  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_HSOL = 4'd12;
  localparam logic [NOTE_W-1:0] NOTE_HLA  = 4'd13;
  localparam logic [NOTE_W-1:0] NOTE_HTI  = 4'd14;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitHi,
    StWaitLo,
    StGap,
    StDone
  } seqState_e;

endpackage

// File: rtl/song_rom.sv
// Fixed melody table: address to note code; addresses past SONG_LEN read as a rest.
module song_rom
  import piano_pkg::*;
#(
  parameter int unsigned SONG_LEN = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic [ADDR_W-1:0] iAddr,
  output logic [NOTE_W-1:0] oNote
);

  always_comb begin
    oNote = NOTE_REST;
    if (32'(iAddr) < SONG_LEN) begin
      case (32'(iAddr))
        0:       oNote = NOTE_DO;
        1:       oNote = NOTE_MI;
        2:       oNote = NOTE_SOL;
        3:       oNote = NOTE_REST;
        4:       oNote = NOTE_SOL;
        5:       oNote = NOTE_MI;
        6:       oNote = NOTE_DO;
        7:       oNote = NOTE_REST;
        8:       oNote = NOTE_HDO;
        9:       oNote = NOTE_TI;
        10:      oNote = NOTE_LA;
        11:      oNote = NOTE_SOL;
        12:      oNote = NOTE_FA;
        13:      oNote = NOTE_MI;
        14:      oNote = NOTE_RE;
        15:      oNote = NOTE_DO;
        default: oNote = NOTE_REST;
      endcase
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through song_rom, pulsing the buzzer counter per note and waiting out ring + gap.
// Define SEQ_LOOP_EN to replay the song endlessly instead of ending with oDone.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned SONG_LEN     = 16,
  parameter int unsigned GAP_CYCLES   = 50000,
  parameter int unsigned RING_TIMEOUT = 3
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iPlay,
  input  logic              iStop,
  input  logic              iRing,
  output logic              oNoteStart,
  output logic [NOTE_W-1:0] oNote,
  output logic              oBusy,
  output logic              oDone
);

  localparam int unsigned ADDR_W = $clog2(SONG_LEN);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TO_W   = $clog2(RING_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(RING_TIMEOUT);

  seqState_e         stateQ;
  logic [ADDR_W-1:0] addrQ;
  logic [GAP_W-1:0]  gapCntQ;
  logic [TO_W-1:0]   toCntQ;

  logic [ADDR_W-1:0] addrInc;
  logic [ADDR_W-1:0] romAddr;
  logic [NOTE_W-1:0] romNote;
  logic [TO_W-1:0]   toInc;

  // The ROM is read at the address about to be entered so oNote is valid in the pulse cycle.
  always_comb begin
    addrInc = (addrQ == LAST_ADDR) ? '0 : addrQ + 1'b1;
    romAddr = (stateQ == StGap) ? addrInc : '0;
    toInc   = toCntQ + 1'b1;
  end

  song_rom #(
    .SONG_LEN (SONG_LEN),
    .ADDR_W   (ADDR_W)
  ) uSongRom (
    .iAddr (romAddr),
    .oNote (romNote)
  );

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      stateQ     <= StIdle;
      addrQ      <= '0;
      gapCntQ    <= '0;
      toCntQ     <= '0;
      oNoteStart <= 1'b0;
      oNote      <= NOTE_REST;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      oNoteStart <= 1'b0;
      oDone      <= 1'b0;
      if (iStop && (stateQ != StIdle)) begin
        stateQ <= StIdle;
        oNote  <= NOTE_REST;
        oBusy  <= 1'b0;
      end else begin
        unique case (stateQ)
          StIdle: begin
            if (!iStop && iPlay) begin
              stateQ     <= StStart;
              addrQ      <= '0;
              oNoteStart <= 1'b1;
              oNote      <= romNote;
              oBusy      <= 1'b1;
            end
          end
          StStart: begin
            stateQ <= StWaitHi;
            toCntQ <= '0;
          end
          StWaitHi: begin
            if (iRing) begin
              stateQ <= StWaitLo;
            end else begin
              toCntQ <= toInc;
              // Counter never answered: drop this note but keep the song going.
              if (toInc == TO_LIMIT) begin
                stateQ  <= StGap;
                gapCntQ <= GAP_LOAD;
              end
            end
          end
          StWaitLo: begin
            if (!iRing) begin
              stateQ  <= StGap;
              gapCntQ <= GAP_LOAD;
              oNote   <= NOTE_REST;
            end
          end
          StGap: begin
            if (gapCntQ != '0) begin
              gapCntQ <= gapCntQ - 1'b1;
`ifdef SEQ_LOOP_EN
            end else begin
              stateQ     <= StStart;
              addrQ      <= addrInc;
              oNoteStart <= 1'b1;
              oNote      <= romNote;
            end
`else
            end else if (addrQ == LAST_ADDR) begin
              stateQ <= StDone;
              oDone  <= 1'b1;
              oNote  <= NOTE_REST;
            end else begin
              stateQ     <= StStart;
              addrQ      <= addrInc;
              oNoteStart <= 1'b1;
              oNote      <= romNote;
            end
`endif
          end
          StDone: begin
            stateQ <= StIdle;
            oBusy  <= 1'b0;
          end
          default: begin
            stateQ <= StIdle;
            oBusy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a behavioural buzzer counter that rings 10 cycles.
module tb_note_sequencer;

  logic       iClk = 1'b0;
  logic       iReset_n;
  logic       iPlay;
  logic       iStop;
  logic       iRing;
  logic       oNoteStart;
  logic [3:0] oNote;
  logic       oBusy;
  logic       oDone;

  int errors = 0;
  int checks = 0;

  always #5 iClk = ~iClk;

  note_sequencer #(
    .SONG_LEN     (4),
    .GAP_CYCLES   (3),
    .RING_TIMEOUT (3)
  ) dut (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iPlay      (iPlay),
    .iStop      (iStop),
    .iRing      (iRing),
    .oNoteStart (oNoteStart),
    .oNote      (oNote),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  // Buzzer counter model: ring rises the edge after it latches the pulse, high 10 cycles.
  bit ringEn = 1'b1;
  int rc = 0;
  always @(posedge iClk) begin
    if (oNoteStart && ringEn) rc <= 11;
    else if (rc != 0) rc <= rc - 1;
  end
  assign iRing = (rc != 0) && (rc <= 10);

  // Event log sampled on the falling edge.
  int   cyc = 0;
  int   pCyc[64];
  int   pNote[64];
  int   nPulse = 0;
  int   nDone = 0;
  int   doneCyc = 0;
  int   nFall = 0;
  int   lastFall = 0;
  logic ringPrev = 1'b0;
  always @(negedge iClk) begin
    cyc <= cyc + 1;
    if (oNoteStart && nPulse < 64) begin
      pCyc[nPulse]  <= cyc;
      pNote[nPulse] <= int'(oNote);
      nPulse        <= nPulse + 1;
    end
    if (oDone) begin
      nDone   <= nDone + 1;
      doneCyc <= cyc;
    end
    if (ringPrev && !iRing) begin
      nFall    <= nFall + 1;
      lastFall <= cyc;
    end
    ringPrev <= iRing;
  end

  int expNotes[4] = '{1, 3, 5, 0};

  task automatic playPulse();
    @(negedge iClk) iPlay = 1'b1;
    @(negedge iClk) iPlay = 1'b0;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0;
    iPlay    = 1'b0;
    iStop    = 1'b0;
    repeat (3) @(negedge iClk);
    checks++; if (oNoteStart !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", oNoteStart); end
    checks++; if (oNote !== 4'd0) begin errors++; $display("FAIL reset_note: got %0d expected 0", oNote); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    checks++; if (oDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", oDone); end
    iReset_n = 1'b1;
    repeat (2) @(negedge iClk);
  endtask

  task automatic test_song();
    int b, d0;
    b = nPulse; d0 = nDone; ringEn = 1'b1;
    playPulse();
    for (int i = 0; i < 200 && nDone == d0; i++) @(negedge iClk);
    repeat (2) @(negedge iClk);
    checks++; if (nDone !== d0 + 1) begin errors++; $display("FAIL song_done_count: got %0d expected %0d", nDone - d0, 1); end
    checks++; if (nPulse - b !== 4) begin errors++; $display("FAIL song_pulses: got %0d expected 4", nPulse - b); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pNote[b+k] !== expNotes[k]) begin
        errors++; $display("FAIL song_note[%0d]: got %0d expected %0d", k, pNote[b+k], expNotes[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (pCyc[b+k] - pCyc[b+k-1] !== 16) begin
        errors++; $display("FAIL song_period[%0d]: got %0d expected 16", k, pCyc[b+k] - pCyc[b+k-1]);
      end
    end
    checks++; if (doneCyc - lastFall !== 4) begin errors++; $display("FAIL song_done_delay: got %0d expected 4", doneCyc - lastFall); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL song_busy_after: got %b expected 0", oBusy); end
  endtask

  task automatic test_stop();
    int b, d0;
    b = nPulse; d0 = nDone; ringEn = 1'b1;
    playPulse();
    for (int i = 0; i < 100 && nPulse < b + 2; i++) @(negedge iClk);
    for (int i = 0; i < 20 && iRing !== 1'b1; i++) @(negedge iClk);
    @(negedge iClk);
    checks++; if (oNote !== 4'd3) begin errors++; $display("FAIL stop_note_before: got %0d expected 3", oNote); end
    iStop = 1'b1;
    @(negedge iClk);
    checks++; if (oNote !== 4'd0) begin errors++; $display("FAIL stop_note: got %0d expected 0", oNote); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", oBusy); end
    iStop = 1'b0;
    repeat (60) @(negedge iClk);
    checks++; if (nPulse - b !== 2) begin errors++; $display("FAIL stop_pulses: got %0d expected 2", nPulse - b); end
    checks++; if (nDone !== d0) begin errors++; $display("FAIL stop_no_done: got %0d expected 0", nDone - d0); end
  endtask

  task automatic test_timeout();
    int b, d0;
    b = nPulse; d0 = nDone; ringEn = 1'b0;
    playPulse();
    for (int i = 0; i < 200 && nDone == d0; i++) @(negedge iClk);
    repeat (2) @(negedge iClk);
    checks++; if (nPulse - b !== 4) begin errors++; $display("FAIL timeout_pulses: got %0d expected 4", nPulse - b); end
    checks++; if (nDone !== d0 + 1) begin errors++; $display("FAIL timeout_done: got %0d expected 1", nDone - d0); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (pCyc[b+k] - pCyc[b+k-1] !== 7) begin
        errors++; $display("FAIL timeout_period[%0d]: got %0d expected 7", k, pCyc[b+k] - pCyc[b+k-1]);
      end
    end
    checks++; if (doneCyc - pCyc[b+3] !== 7) begin errors++; $display("FAIL timeout_done_delay: got %0d expected 7", doneCyc - pCyc[b+3]); end
    ringEn = 1'b1;
  endtask

  task automatic test_play_stop();
    int b, d0;
    b = nPulse; d0 = nDone;
    iPlay = 1'b1; iStop = 1'b1;
    repeat (4) @(negedge iClk);
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL playstop_busy: got %b expected 0", oBusy); end
    checks++; if (nPulse !== b) begin errors++; $display("FAIL playstop_pulses: got %0d expected 0", nPulse - b); end
    iStop = 1'b0;
    for (int i = 0; i < 200 && oDone !== 1'b1; i++) @(negedge iClk);
    iPlay = 1'b0;
    repeat (5) @(negedge iClk);
    checks++; if (nPulse - b !== 4) begin errors++; $display("FAIL playhold_pulses: got %0d expected 4", nPulse - b); end
    checks++; if (nDone !== d0 + 1) begin errors++; $display("FAIL playhold_done: got %0d expected 1", nDone - d0); end
  endtask

  task automatic test_reset_mid();
    int b, f0, d0;
    b = nPulse; f0 = nFall; ringEn = 1'b1;
    playPulse();
    for (int i = 0; i < 100 && nPulse < b + 2; i++) @(negedge iClk);
    for (int i = 0; i < 40 && nFall < f0 + 2; i++) @(negedge iClk);
    iReset_n = 1'b0;
    @(negedge iClk);
    checks++; if (oNote !== 4'd0) begin errors++; $display("FAIL rstmid_note: got %0d expected 0", oNote); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", oBusy); end
    checks++; if (oNoteStart !== 1'b0) begin errors++; $display("FAIL rstmid_start: got %b expected 0", oNoteStart); end
    iReset_n = 1'b1;
    repeat (2) @(negedge iClk);
    b = nPulse; d0 = nDone;
    playPulse();
    for (int i = 0; i < 200 && nDone == d0; i++) @(negedge iClk);
    repeat (2) @(negedge iClk);
    checks++; if (pNote[b] !== 1) begin errors++; $display("FAIL rstmid_first_note: got %0d expected 1", pNote[b]); end
    checks++; if (nPulse - b !== 4) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 4", nPulse - b); end
  endtask

  task automatic test_loop();
    int b, d0;
    b = nPulse; d0 = nDone; ringEn = 1'b1;
    playPulse();
    for (int i = 0; i < 200 && nPulse < b + 5; i++) @(negedge iClk);
    @(negedge iClk);
    checks++; if (nPulse - b < 5) begin errors++; $display("FAIL loop_pulses: got %0d expected 5", nPulse - b); end
    checks++; if (pNote[b+4] !== 1) begin errors++; $display("FAIL loop_wrap_note: got %0d expected 1", pNote[b+4]); end
    checks++; if (nDone !== d0) begin errors++; $display("FAIL loop_no_done: got %0d expected 0", nDone - d0); end
    iStop = 1'b1;
    @(negedge iClk);
    iStop = 1'b0;
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL loop_stop_busy: got %b expected 0", oBusy); end
  endtask

  initial begin
    test_reset();
`ifdef SEQ_LOOP_EN
    test_loop();
`else
    test_song();
    test_stop();
    test_timeout();
    test_play_stop();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
